multiport_memory: RTL and testbench
===================================

Name: multiport_memory

Overview:
- Parametrised successor to the team's single-read byte-masked memory.
- One byte-masked write port and NUM_READ_PORTS independent read ports.
- Per-port read latency is selectable: 0 (showahead), 1 or 2 cycles. Each port has a read-valid output and a selectable read-during-write policy.
- Used as register-file / cache-tag / scratchpad storage in cpphdl pipelines.

Parameters:
- MEM_WIDTH_BYTES, 8, word width in bytes; data width is MEM_WIDTH_BYTES*8.
- MEM_DEPTH, 256, number of words; power of two, at least 2.
- NUM_READ_PORTS, 2, number of read ports, 1..8.
- READ_LATENCY, 1, read latency in cycles: 0 = showahead (combinational), 1, or 2 (registered output stage).
- WRITE_FIRST, 0, read-during-write to the same address: 1 returns the new (masked-merged) data, 0 returns the old data.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- write_addr_in  in  $clog2(MEM_DEPTH)  write word address
- write_in  in  1  write strobe
- write_data_in  in  MEM_WIDTH_BYTES*8  write data
- write_mask_in  in  MEM_WIDTH_BYTES  byte enables; bit i covers data bits [i*8+7:i*8]
- read_addr_in  in  NUM_READ_PORTS*$clog2(MEM_DEPTH)  read addresses; port p occupies slice p
- read_in  in  NUM_READ_PORTS  read strobes
- read_data_out  out  NUM_READ_PORTS*MEM_WIDTH_BYTES*8  read data; port p occupies slice p
- read_valid_out  out  NUM_READ_PORTS  per-port data valid
- busy_out  out  1  high while the memory is unavailable (clear in progress)
- debugen_in  in  1  enables per-cycle $write trace of port activity

Behaviour:
- Write: when write_in is high and busy_out is low, update only the enabled bytes of buffer[write_addr_in] at the clock edge. Masked-off bytes keep their value. An all-zero mask is a no-op.
- Read, READ_LATENCY=0:
  - read_data_out[p] = buffer[read_addr_in[p]] combinationally.
  - read_valid_out[p] = read_in[p] & ~busy_out.
- Read, READ_LATENCY=1:
  - Address sampled at edge N when read_in[p] is high; data and valid present during cycle N+1.
  - When read_in[p] is low, valid drops next cycle and data holds its last value.
- Read, READ_LATENCY=2: a second register stage after the latency-1 stage; data and valid present during cycle N+2. No stall; the pipeline always advances.
- Read-during-write, same address and same edge:
  - WRITE_FIRST=1: the returned word is old data with the enabled bytes replaced by write_data_in. Applies to all latencies, including the combinational latency-0 path.
  - WRITE_FIRST=0: the returned word is the pre-write contents.
- Different ports reading the same address is legal. Each port has its own pipeline and no arbitration.
- Out-of-range addresses cannot occur (power-of-two depth).
- Reset:
  - read_valid_out = 0 on all ports; pipeline valid bits = 0; read_data_out registers = 0.
  - Memory contents are untouched unless MULTIPORT_MEMORY_CLEAR_EN is defined.
  - Reset mid-read discards all in-flight reads.
- Reads and writes issued while busy_out=1 are ignored, and no valid is produced.
- Debug: when debugen_in is high, print one line per cycle with write strobe/data/address/mask and, per port, read strobe/address/data/valid.

Optional Feature:
- MULTIPORT_MEMORY_CLEAR_EN defined:
  - Reset starts a clear FSM with states IDLE and CLEAR.
  - reset forces CLEAR with clear_addr=0.
  - In CLEAR, write 0 to buffer[clear_addr] each cycle and increment clear_addr.
  - After writing MEM_DEPTH-1, go to IDLE.
  - busy_out=1 throughout CLEAR, so it lasts exactly MEM_DEPTH cycles after reset deasserts.
  - Reset asserted during CLEAR restarts the clear at address 0.
- Not defined: no FSM; busy_out is tied to 0; contents are undefined after power-up.

Decomposition:
- Shared package multiport_memory_pkg:
  - constants for the latency codes (LAT_SHOWAHEAD=0, LAT_REG=1, LAT_REG2=2);
  - function mask_expand(byte mask) -> bit mask, reused by the write path and the WRITE_FIRST bypass merge.
- One natural sub-module, multiport_memory_read_port: per-port address register, bypass compare/merge, latency pipeline and valid tracking. Instantiated NUM_READ_PORTS times in a generate loop.

Test Plan:
- Default parameters: write 0x1122334455667788 to address 5 with mask 0xFF, then read port 0 address 5 -> data 0x1122334455667788 with read_valid_out[0]=1 exactly 1 cycle after the request.
- Write 0xAAAA... to address 7 with mask 0xFF, then 0x5555... with mask 0x0F -> a read returns 0xAAAAAAAA55555555.
- Same-edge write and read, address 3, old 0, new 0xFF..FF, mask 0x01 -> WRITE_FIRST=0 returns 0; WRITE_FIRST=1 returns 0x00000000000000FF.
- READ_LATENCY=2, NUM_READ_PORTS=3, back-to-back reads of addresses 1, 2, 3 on all ports -> each port returns the correct words on cycles N+2, N+3, N+4 with valid continuously high.
- Reset asserted with reads in flight -> read_valid_out=0 on the next cycle and no stale valid afterwards.
- With MULTIPORT_MEMORY_CLEAR_EN and MEM_DEPTH=16: reset, then busy_out=1 for 16 cycles while writes are ignored, then reading every address returns 0.

Source files
------------

// File: rtl/multiport_memory_pkg.sv
// Shared constants and helpers for multiport_memory: latency codes and byte-mask expansion.
// mask_expand works at a fixed maximum width; callers zero-extend in and truncate out.
package multiport_memory_pkg;

   localparam int LAT_SHOWAHEAD  = 0;
   localparam int LAT_REG        = 1;
   localparam int LAT_REG2       = 2;

   localparam int MASK_BYTES_MAX = 64;

   function automatic logic [MASK_BYTES_MAX*8-1:0] mask_expand(input logic [MASK_BYTES_MAX-1:0] mask);
      logic [MASK_BYTES_MAX*8-1:0] bits;
      bits = '0;
      for (int i = 0; i < MASK_BYTES_MAX; i++) begin
         bits[i*8 +: 8] = {8{mask[i]}};
      end
      return bits;
   endfunction

endpackage

// File: rtl/multiport_memory_read_port.sv
// One read port: same-edge write bypass merge plus a 0/1/2-cycle output pipeline with valid tracking.
// No stall: the pipeline always advances; reads are dropped while the memory is busy.
module multiport_memory_read_port
   import multiport_memory_pkg::*;
#(
   parameter int MEM_WIDTH_BYTES = 8,
   parameter int MEM_DEPTH       = 256,
   parameter int READ_LATENCY    = 1,
   parameter int WRITE_FIRST     = 0
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           i_busy,
   input  logic                           i_read,
   input  logic [$clog2(MEM_DEPTH)-1:0]   i_read_addr,
   input  logic [MEM_WIDTH_BYTES*8-1:0]   i_mem_word,
   input  logic                           i_wr_en,
   input  logic [$clog2(MEM_DEPTH)-1:0]   i_wr_addr,
   input  logic [MEM_WIDTH_BYTES*8-1:0]   i_wr_data,
   input  logic [MEM_WIDTH_BYTES-1:0]     i_wr_mask,
   output logic [MEM_WIDTH_BYTES*8-1:0]   o_read_data,
   output logic                           o_read_valid
);

   localparam int DW = MEM_WIDTH_BYTES * 8;
   localparam int MB = MASK_BYTES_MAX;
   localparam int MW = MASK_BYTES_MAX * 8;

   logic          w_take;
   logic          w_hit;
   logic [DW-1:0] w_merged;
   logic [DW-1:0] w_word;

   assign w_take   = i_read & ~i_busy;
   assign w_hit    = i_wr_en & (i_wr_addr == i_read_addr);
   assign w_merged = DW'((MW'(i_mem_word) & ~mask_expand(MB'(i_wr_mask)))
                       | (MW'(i_wr_data) &  mask_expand(MB'(i_wr_mask))));
   assign w_word   = ((WRITE_FIRST != 0) && w_hit) ? w_merged : i_mem_word;

   generate
      if (READ_LATENCY == LAT_SHOWAHEAD) begin : g_lat0
         logic w_unused;
         assign w_unused     = clk ^ reset;
         assign o_read_data  = w_word;
         assign o_read_valid = w_take;
      end else begin : g_reg
         logic [DW-1:0] r_data1;
         logic          r_vld1;

         // Data holds its last value when no read is taken.
         always_ff @(posedge clk) begin
            if (reset) begin
               r_vld1  <= 1'b0;
               r_data1 <= '0;
            end else begin
               r_vld1 <= w_take;
               if (w_take) begin
                  r_data1 <= w_word;
               end
            end
         end

         if (READ_LATENCY == LAT_REG) begin : g_lat1
            assign o_read_data  = r_data1;
            assign o_read_valid = r_vld1;
         end else begin : g_lat2
            logic [DW-1:0] r_data2;
            logic          r_vld2;

            always_ff @(posedge clk) begin
               if (reset) begin
                  r_vld2  <= 1'b0;
                  r_data2 <= '0;
               end else begin
                  r_vld2 <= r_vld1;
                  if (r_vld1) begin
                     r_data2 <= r_data1;
                  end
               end
            end

            assign o_read_data  = r_data2;
            assign o_read_valid = r_vld2;
         end
      end
   endgenerate

endmodule

// File: rtl/multiport_memory.sv
// Byte-masked single-write, NUM_READ_PORTS-read memory with per-port 0/1/2-cycle latency.
// MULTIPORT_MEMORY_CLEAR_EN: reset zeroes every word, holding busy_out for MEM_DEPTH cycles.
module multiport_memory
   import multiport_memory_pkg::*;
#(
   parameter int MEM_WIDTH_BYTES = 8,
   parameter int MEM_DEPTH       = 256,
   parameter int NUM_READ_PORTS  = 2,
   parameter int READ_LATENCY    = 1,
   parameter int WRITE_FIRST     = 0
) (
   input  logic                                          clk,
   input  logic                                          reset,
   input  logic [$clog2(MEM_DEPTH)-1:0]                  write_addr_in,
   input  logic                                          write_in,
   input  logic [MEM_WIDTH_BYTES*8-1:0]                  write_data_in,
   input  logic [MEM_WIDTH_BYTES-1:0]                    write_mask_in,
   input  logic [NUM_READ_PORTS*$clog2(MEM_DEPTH)-1:0]   read_addr_in,
   input  logic [NUM_READ_PORTS-1:0]                     read_in,
   output logic [NUM_READ_PORTS*MEM_WIDTH_BYTES*8-1:0]   read_data_out,
   output logic [NUM_READ_PORTS-1:0]                     read_valid_out,
   output logic                                          busy_out,
   input  logic                                          debugen_in
);

   localparam int DW = MEM_WIDTH_BYTES * 8;
   localparam int AW = $clog2(MEM_DEPTH);
   localparam int MB = MASK_BYTES_MAX;
   localparam int MW = MASK_BYTES_MAX * 8;

   logic [DW-1:0] r_mem [MEM_DEPTH];
   logic          w_wr_en;
   logic [DW-1:0] w_wr_merged;

   assign w_wr_en     = write_in & ~busy_out;
   assign w_wr_merged = DW'((MW'(r_mem[write_addr_in]) & ~mask_expand(MB'(write_mask_in)))
                          | (MW'(write_data_in)        &  mask_expand(MB'(write_mask_in))));

`ifdef MULTIPORT_MEMORY_CLEAR_EN
   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_CLEAR = 1'b1;

   logic [0:0]    r_state;
   logic [AW-1:0] r_clear_addr;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_CLEAR;
         r_clear_addr <= '0;
      end else if (r_state == ST_CLEAR) begin
         r_clear_addr <= r_clear_addr + AW'(1);
         if (r_clear_addr == AW'(MEM_DEPTH - 1)) begin
            r_state <= ST_IDLE;
         end
      end
   end

   assign busy_out = (r_state == ST_CLEAR);

   always_ff @(posedge clk) begin
      if (r_state == ST_CLEAR) begin
         r_mem[r_clear_addr] <= '0;
      end else if (w_wr_en) begin
         r_mem[write_addr_in] <= w_wr_merged;
      end
   end
`else
   assign busy_out = 1'b0;

   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[write_addr_in] <= w_wr_merged;
      end
   end
`endif

   generate
      for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_port
         logic [AW-1:0] w_addr;
         assign w_addr = read_addr_in[p*AW +: AW];

         multiport_memory_read_port #(
            .MEM_WIDTH_BYTES (MEM_WIDTH_BYTES),
            .MEM_DEPTH       (MEM_DEPTH),
            .READ_LATENCY    (READ_LATENCY),
            .WRITE_FIRST     (WRITE_FIRST)
         ) u_port (
            .clk          (clk),
            .reset        (reset),
            .i_busy       (busy_out),
            .i_read       (read_in[p]),
            .i_read_addr  (w_addr),
            .i_mem_word   (r_mem[w_addr]),
            .i_wr_en      (w_wr_en),
            .i_wr_addr    (write_addr_in),
            .i_wr_data    (write_data_in),
            .i_wr_mask    (write_mask_in),
            .o_read_data  (read_data_out[p*DW +: DW]),
            .o_read_valid (read_valid_out[p])
         );
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (debugen_in) begin
         $write("%0t wr=%b a=%h d=%h m=%h |", $time, write_in, write_addr_in, write_data_in, write_mask_in);
         for (int p = 0; p < NUM_READ_PORTS; p++) begin
            $write(" p%0d rd=%b a=%h d=%h v=%b", p, read_in[p], read_addr_in[p*AW +: AW],
                   read_data_out[p*DW +: DW], read_valid_out[p]);
         end
         $write("\n");
      end
   end

endmodule

// File: tb/tb_multiport_memory.sv
// Bench for multiport_memory: three configurations (lat1/read-first, lat2/write-first/3 ports, lat0/write-first)
// driven with directed vectors; expected responses are queued and checked by a cycle-tagged monitor.
module tb_multiport_memory;

   logic clk;
   logic reset;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   // A: defaults (2 ports, latency 1, read-first, depth 256)
   logic [7:0]   a_wa;  logic a_we;  logic [63:0] a_wd;  logic [7:0] a_wm;
   logic [15:0]  a_ra;  logic [1:0] a_re;  logic [127:0] a_rd;  logic [1:0] a_rv;
   logic         a_busy; logic a_dbg;
   // B: 3 ports, latency 2, write-first, depth 16
   logic [3:0]   b_wa;  logic b_we;  logic [63:0] b_wd;  logic [7:0] b_wm;
   logic [11:0]  b_ra;  logic [2:0] b_re;  logic [191:0] b_rd;  logic [2:0] b_rv;
   logic         b_busy;
   // C: 1 port, latency 0, write-first, depth 16
   logic [3:0]   c_wa;  logic c_we;  logic [63:0] c_wd;  logic [7:0] c_wm;
   logic [3:0]   c_ra;  logic c_re;  logic [63:0] c_rd;  logic c_rv;
   logic         c_busy;
   logic         dbg_off;

   multiport_memory u_a (
      .clk(clk), .reset(reset), .write_addr_in(a_wa), .write_in(a_we), .write_data_in(a_wd),
      .write_mask_in(a_wm), .read_addr_in(a_ra), .read_in(a_re), .read_data_out(a_rd),
      .read_valid_out(a_rv), .busy_out(a_busy), .debugen_in(a_dbg));

   multiport_memory #(.MEM_DEPTH(16), .NUM_READ_PORTS(3), .READ_LATENCY(2), .WRITE_FIRST(1)) u_b (
      .clk(clk), .reset(reset), .write_addr_in(b_wa), .write_in(b_we), .write_data_in(b_wd),
      .write_mask_in(b_wm), .read_addr_in(b_ra), .read_in(b_re), .read_data_out(b_rd),
      .read_valid_out(b_rv), .busy_out(b_busy), .debugen_in(dbg_off));

   multiport_memory #(.MEM_DEPTH(16), .NUM_READ_PORTS(1), .READ_LATENCY(0), .WRITE_FIRST(1)) u_c (
      .clk(clk), .reset(reset), .write_addr_in(c_wa), .write_in(c_we), .write_data_in(c_wd),
      .write_mask_in(c_wm), .read_addr_in(c_ra), .read_in(c_re), .read_data_out(c_rd),
      .read_valid_out(c_rv), .busy_out(c_busy), .debugen_in(dbg_off));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          inst;
      int          port;
      int          due;
      logic [63:0] data;
   } exp_t;

   exp_t sb[$];

   task automatic sb_push(input int inst, input int port, input int due, input logic [63:0] data);
      exp_t e;
      e.inst = inst; e.port = port; e.due = due; e.data = data;
      sb.push_back(e);
   endtask

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   task automatic chk_port(input int inst, input int p, input logic vld, input logic [63:0] dat);
      int idx;
      idx = -1;
      foreach (sb[i]) begin
         if (sb[i].inst == inst && sb[i].port == p && sb[i].due == cyc) idx = i;
      end
      if (idx >= 0) begin
         n_cmp++;
         if (!vld || dat !== sb[idx].data) begin
            n_bad++;
            $display("FAIL sb_inst%0d_port%0d cyc=%0d: got vld=%b data=%h, expected vld=1 data=%h",
                     inst, p, cyc, vld, dat, sb[idx].data);
         end
         sb.delete(idx);
      end else if (vld) begin
         n_cmp++;
         n_bad++;
         $display("FAIL sb_inst%0d_port%0d cyc=%0d: unexpected valid data=%h, expected no valid",
                  inst, p, cyc, dat);
      end
   endtask

   always @(negedge clk) begin
      for (int p = 0; p < 2; p++) chk_port(0, p, a_rv[p], a_rd[p*64 +: 64]);
      for (int p = 0; p < 3; p++) chk_port(1, p, b_rv[p], b_rd[p*64 +: 64]);
      chk_port(2, 0, c_rv, c_rd);
   end

   task automatic idle_all();
      a_we = 1'b0; a_re = '0; a_dbg = 1'b0;
      b_we = 1'b0; b_re = '0;
      c_we = 1'b0; c_re = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      idle_all();
   endtask

   task automatic a_wr(input logic [7:0] ad, input logic [63:0] d, input logic [7:0] m);
      a_we = 1'b1; a_wa = ad; a_wd = d; a_wm = m;
   endtask
   task automatic a_rdq(input int p, input logic [7:0] ad, input logic [63:0] exp);
      a_re[p] = 1'b1; a_ra[p*8 +: 8] = ad; sb_push(0, p, cyc + 1, exp);
   endtask
   task automatic b_wr(input logic [3:0] ad, input logic [63:0] d, input logic [7:0] m);
      b_we = 1'b1; b_wa = ad; b_wd = d; b_wm = m;
   endtask
   task automatic b_rdq(input int p, input logic [3:0] ad, input logic [63:0] exp);
      b_re[p] = 1'b1; b_ra[p*4 +: 4] = ad; sb_push(1, p, cyc + 2, exp);
   endtask
   task automatic c_wr(input logic [3:0] ad, input logic [63:0] d, input logic [7:0] m);
      c_we = 1'b1; c_wa = ad; c_wd = d; c_wm = m;
   endtask
   task automatic c_rdq(input logic [3:0] ad, input logic [63:0] exp);
      c_re = 1'b1; c_ra = ad; sb_push(2, 0, cyc, exp);
   endtask

   initial begin
      int na;
      int nb;
      logic done;
      dbg_off = 1'b0;
      a_wa = '0; a_wd = '0; a_wm = '0; a_ra = '0;
      b_wa = '0; b_wd = '0; b_wm = '0; b_ra = '0;
      c_wa = '0; c_wd = '0; c_wm = '0; c_ra = '0;
      idle_all();
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      check("reset_valid_a", 64'(a_rv), 64'h0);
      check("reset_valid_b", 64'(b_rv), 64'h0);
      check("reset_valid_c", 64'(c_rv), 64'h0);

`ifdef MULTIPORT_MEMORY_CLEAR_EN
      na = 0; nb = 0; done = 1'b0;
      for (int i = 0; i < 400 && !done; i++) begin
         @(negedge clk);
         if (a_busy) na++;
         if (b_busy) nb++;
         b_we = (i == 8); b_wa = 4'd0; b_wd = '1; b_wm = 8'hFF;
         done = !a_busy && !b_busy && !c_busy;
      end
      b_we = 1'b0;
      @(posedge clk);
      #1;
      check("clear_done", 64'(done), 64'h1);
      check("clear_cycles_a", 64'(na), 64'd256);
      check("clear_cycles_b", 64'(nb), 64'd16);
      for (int k = 0; k < 16; k++) begin
         b_rdq(k % 3, 4'(k), 64'h0);
         tick();
      end
      repeat (3) tick();
`else
      na = 0; nb = 0; done = 1'b1;
      check("busy_a", 64'(a_busy), 64'h0);
      check("busy_b", 64'(b_busy), 64'h0);
      check("busy_c", 64'(c_busy), 64'h0);
`endif

      // A: latency 1, read-first
      a_wr(8'd5, 64'h1122334455667788, 8'hFF); tick();
      a_rdq(0, 8'd5, 64'h1122334455667788); a_dbg = 1'b1; tick();
      a_wr(8'd7, 64'hAAAAAAAAAAAAAAAA, 8'hFF); tick();
      a_wr(8'd7, 64'h5555555555555555, 8'h0F); tick();
      a_rdq(1, 8'd7, 64'hAAAAAAAA55555555); tick();
      a_wr(8'd3, 64'h0, 8'hFF); tick();
      a_wr(8'd3, '1, 8'h01); a_rdq(0, 8'd3, 64'h0); tick();
      a_rdq(0, 8'd3, 64'h00000000000000FF); a_wr(8'd5, 64'h0, 8'h00); tick();
      a_rdq(0, 8'd5, 64'h1122334455667788); a_rdq(1, 8'd5, 64'h1122334455667788); tick();
      a_wr(8'd9, '1, 8'hFF); tick();
      a_wr(8'd9, 64'h0123456789ABCDEF, 8'hA5); tick();
      a_rdq(1, 8'd9, 64'h01FF45FFFFABFFEF); tick();
      repeat (2) tick();

      // B: latency 2, write-first, back-to-back reads on all ports
      for (int k = 1; k <= 3; k++) begin
         b_wr(4'(k), {8{8'(k * 17)}}, 8'hFF); tick();
      end
      for (int k = 1; k <= 3; k++) begin
         for (int p = 0; p < 3; p++) b_rdq(p, 4'(k), {8{8'(k * 17)}});
         tick();
      end
      repeat (3) tick();
      b_wr(4'd4, 64'h0, 8'hFF); tick();
      b_wr(4'd4, '1, 8'h01); b_rdq(2, 4'd4, 64'h00000000000000FF); b_rdq(0, 4'd1, 64'h1111111111111111); tick();
      b_wr(4'd2, '1, 8'h80); b_rdq(1, 4'd2, 64'hFF22222222222222); tick();
      repeat (3) tick();

      // C: latency 0 showahead, write-first bypass on the combinational path
      c_wr(4'd3, 64'h0, 8'hFF); tick();
      c_wr(4'd3, '1, 8'h01); c_rdq(4'd3, 64'h00000000000000FF); tick();
      c_wr(4'd6, 64'hCAFEF00DDEADBEEF, 8'hFF); tick();
      c_rdq(4'd6, 64'hCAFEF00DDEADBEEF); tick();
      c_wr(4'd6, 64'h5A5A5A5A5A5A5A5A, 8'h80); c_rdq(4'd6, 64'h5AFEF00DDEADBEEF); tick();
      repeat (2) tick();

      // Reset with reads in flight: nothing may come out afterwards
      b_re = 3'b111; b_ra = {3{4'd1}}; tick();
      reset = 1'b1; a_re = 2'b01; a_ra = 16'h0005; tick();
      reset = 1'b0;
      check("flush_valid_a", 64'(a_rv), 64'h0);
      check("flush_valid_b", 64'(b_rv), 64'h0);
      repeat (4) tick();

      check("scoreboard_drained", 64'(sb.size()), 64'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
